// File: rtl/cnn_layer_seq_pkg.sv
// rtl/cnn_layer_seq_pkg.sv - shared state encodings, phase constants and helpers for the layer sequencer
package cnn_layer_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_CSYNC = 3'd2,
    ST_DATA  = 3'd3,
    ST_POST  = 3'd4
  } state_e;

  localparam logic PH_PRE  = 1'b0;
  localparam logic PH_POST = 1'b1;

  localparam int PERF_W = 32;

  // Saturating increment for the performance counters.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/cnn_layer_seq_if.sv
// rtl/cnn_layer_seq_if.sv - layer register, sync-handshake and scan-output bundle (CNN_CTRL_PERF_EN adds perf counters)
interface cnn_layer_seq_if #(
  parameter int W_SIZE    = 16,
  parameter int W_CHANNEL = 10,
  parameter int W_STRIDE  = 2
);
  logic [W_SIZE-1:0]    q_width;
  logic [W_SIZE-1:0]    q_height;
  logic [W_CHANNEL-1:0] q_channel;
  logic [W_CHANNEL-1:0] q_channel_out;
  logic [W_STRIDE-1:0]  q_stride;
  logic                 q_skip_pre;
  logic                 q_start;
  logic                 bm_csync_done;
  logic                 pe_csync_done;
  logic                 pp_load_done;
  logic                 pb_sync_done;
  logic                 i_data_ready;

  logic                 o_fb_load_req;
  logic                 o_ctrl_csync_run;
  logic                 o_ctrl_psync_run;
  logic                 o_ctrl_psync_phase;
  logic                 o_ctrl_data_run;
  logic                 o_data_valid;
  logic                 o_is_out_pos;
  logic                 o_is_first_row;
  logic                 o_is_last_row;
  logic                 o_is_first_col;
  logic                 o_is_last_col;
  logic                 o_is_first_chn;
  logic                 o_is_last_chn;
  logic                 o_is_first_chn_out;
  logic                 o_is_last_chn_out;
  logic [W_SIZE-1:0]    o_row;
  logic [W_SIZE-1:0]    o_col;
  logic [W_CHANNEL-1:0] o_chn;
  logic [W_CHANNEL-1:0] o_chn_out;
  logic                 o_layer_done;
  logic                 o_busy;
`ifdef CNN_CTRL_PERF_EN
  logic [31:0]          o_perf_data_cyc;
  logic [31:0]          o_perf_stall_cyc;
  logic [31:0]          o_perf_sync_cyc;
`endif

  modport master (
    output q_width, q_height, q_channel, q_channel_out, q_stride, q_skip_pre, q_start,
    output bm_csync_done, pe_csync_done, pp_load_done, pb_sync_done, i_data_ready,
    input  o_fb_load_req, o_ctrl_csync_run, o_ctrl_psync_run, o_ctrl_psync_phase,
    input  o_ctrl_data_run, o_data_valid, o_is_out_pos,
    input  o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col,
    input  o_is_first_chn, o_is_last_chn, o_is_first_chn_out, o_is_last_chn_out,
    input  o_row, o_col, o_chn, o_chn_out, o_layer_done, o_busy
`ifdef CNN_CTRL_PERF_EN
    , input o_perf_data_cyc, o_perf_stall_cyc, o_perf_sync_cyc
`endif
  );

  modport slave (
    input  q_width, q_height, q_channel, q_channel_out, q_stride, q_skip_pre, q_start,
    input  bm_csync_done, pe_csync_done, pp_load_done, pb_sync_done, i_data_ready,
    output o_fb_load_req, o_ctrl_csync_run, o_ctrl_psync_run, o_ctrl_psync_phase,
    output o_ctrl_data_run, o_data_valid, o_is_out_pos,
    output o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col,
    output o_is_first_chn, o_is_last_chn, o_is_first_chn_out, o_is_last_chn_out,
    output o_row, o_col, o_chn, o_chn_out, o_layer_done, o_busy
`ifdef CNN_CTRL_PERF_EN
    , output o_perf_data_cyc, o_perf_stall_cyc, o_perf_sync_cyc
`endif
  );

endinterface

// File: rtl/cnn_layer_seq_scan_cnt.sv
// rtl/cnn_layer_seq_scan_cnt.sv - nested col/chn/row/chn_out scan counters with stride phase tracking
module cnn_scan_cnt
  import cnn_layer_seq_pkg::*;
#(
  parameter int W_SIZE    = 16,
  parameter int W_CHANNEL = 10,
  parameter int W_STRIDE  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 advance_i,
  input  logic [W_SIZE-1:0]    width_i,
  input  logic [W_SIZE-1:0]    height_i,
  input  logic [W_CHANNEL-1:0] channel_i,
  input  logic [W_CHANNEL-1:0] channel_out_i,
  input  logic [W_STRIDE-1:0]  stride_i,
  output logic [W_SIZE-1:0]    col_o,
  output logic [W_SIZE-1:0]    row_o,
  output logic [W_CHANNEL-1:0] chn_o,
  output logic [W_CHANNEL-1:0] chn_out_o,
  output logic                 first_col_o,
  output logic                 last_col_o,
  output logic                 first_row_o,
  output logic                 last_row_o,
  output logic                 first_chn_o,
  output logic                 last_chn_o,
  output logic                 first_chn_out_o,
  output logic                 last_chn_out_o,
  output logic                 out_pos_o
);

  localparam logic [W_SIZE-1:0]    ONE_S = 1;
  localparam logic [W_CHANNEL-1:0] ONE_C = 1;
  localparam logic [W_STRIDE-1:0]  ONE_T = 1;

  logic [W_SIZE-1:0]    col_q, col_d, row_q, row_d;
  logic [W_CHANNEL-1:0] chn_q, chn_d, cho_q, cho_d;
  logic [W_STRIDE-1:0]  col_ph_q, col_ph_d, row_ph_q, row_ph_d;
  logic [W_STRIDE-1:0]  stride_m1;

  // Stride 0 behaves as stride 1, i.e. every position is an output position.
  assign stride_m1 = (stride_i == '0) ? '0 : stride_i - ONE_T;

  assign last_col_o     = (col_q == width_i - ONE_S);
  assign last_row_o     = (row_q == height_i - ONE_S);
  assign last_chn_o     = (chn_q == channel_i - ONE_C);
  assign last_chn_out_o = (cho_q == channel_out_i - ONE_C);
  assign first_col_o     = (col_q == '0);
  assign first_row_o     = (row_q == '0);
  assign first_chn_o     = (chn_q == '0);
  assign first_chn_out_o = (cho_q == '0);
  assign out_pos_o      = (col_ph_q == '0) && (row_ph_q == '0);

  assign col_o     = col_q;
  assign row_o     = row_q;
  assign chn_o     = chn_q;
  assign chn_out_o = cho_q;

  // Next position: col fastest, then chn, then row, then chn_out; phases track col/row modulo stride.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    chn_d    = chn_q;
    cho_d    = cho_q;
    col_ph_d = col_ph_q;
    row_ph_d = row_ph_q;
    if (clear_i) begin
      col_d    = '0;
      row_d    = '0;
      chn_d    = '0;
      cho_d    = '0;
      col_ph_d = '0;
      row_ph_d = '0;
    end else if (advance_i) begin
      if (!last_col_o) begin
        col_d    = col_q + ONE_S;
        col_ph_d = (col_ph_q == stride_m1) ? '0 : col_ph_q + ONE_T;
      end else begin
        col_d    = '0;
        col_ph_d = '0;
        if (!last_chn_o) begin
          chn_d = chn_q + ONE_C;
        end else begin
          chn_d = '0;
          if (!last_row_o) begin
            row_d    = row_q + ONE_S;
            row_ph_d = (row_ph_q == stride_m1) ? '0 : row_ph_q + ONE_T;
          end else begin
            row_d    = '0;
            row_ph_d = '0;
            cho_d    = last_chn_out_o ? '0 : cho_q + ONE_C;
          end
        end
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      chn_q    <= '0;
      cho_q    <= '0;
      col_ph_q <= '0;
      row_ph_q <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      chn_q    <= chn_d;
      cho_q    <= cho_d;
      col_ph_q <= col_ph_d;
      row_ph_q <= row_ph_d;
    end
  end

endmodule

// File: rtl/cnn_layer_seq.sv
// rtl/cnn_layer_seq.sv - CNN layer sequencer FSM (PRE/CSYNC/DATA/POST); CNN_CTRL_PERF_EN adds cycle counters
module cnn_layer_seq
  import cnn_layer_seq_pkg::*;
#(
  parameter int W_SIZE    = 16,
  parameter int W_CHANNEL = 10,
  parameter int W_STRIDE  = 2
) (
  input logic             clk,
  input logic             rst,
  cnn_layer_seq_if.slave  bus
);

  state_e               state_q;
  logic                 fb_req_q;
  logic                 done_q;
  logic [W_SIZE-1:0]    width_q, height_q;
  logic [W_CHANNEL-1:0] channel_q, channel_out_q;
  logic [W_STRIDE-1:0]  stride_q;

  logic                 start_acc, data_valid, advance, busy;
  logic [W_SIZE-1:0]    col, row;
  logic [W_CHANNEL-1:0] chn, cho;
  logic f_col, l_col, f_row, l_row, f_chn, l_chn, f_cho, l_cho, out_pos;
  logic                 frame_last;

  assign busy       = (state_q != ST_IDLE);
  assign start_acc  = (state_q == ST_IDLE) && bus.q_start;
  assign data_valid = (state_q == ST_DATA);
  assign advance    = data_valid && bus.i_data_ready;
  assign frame_last = l_col && l_chn && l_row;

  cnn_scan_cnt #(
    .W_SIZE    (W_SIZE),
    .W_CHANNEL (W_CHANNEL),
    .W_STRIDE  (W_STRIDE)
  ) u_scan (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (start_acc),
    .advance_i       (advance),
    .width_i         (width_q),
    .height_i        (height_q),
    .channel_i       (channel_q),
    .channel_out_i   (channel_out_q),
    .stride_i        (stride_q),
    .col_o           (col),
    .row_o           (row),
    .chn_o           (chn),
    .chn_out_o       (cho),
    .first_col_o     (f_col),
    .last_col_o      (l_col),
    .first_row_o     (f_row),
    .last_row_o      (l_row),
    .first_chn_o     (f_chn),
    .last_chn_o      (l_chn),
    .first_chn_out_o (f_cho),
    .last_chn_out_o  (l_cho),
    .out_pos_o       (out_pos)
  );

  // Layer FSM: shadows the layer registers on start, pulses fb_load_req on CSYNC entry and done on POST exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      fb_req_q      <= 1'b0;
      done_q        <= 1'b0;
      width_q       <= '0;
      height_q      <= '0;
      channel_q     <= '0;
      channel_out_q <= '0;
      stride_q      <= '0;
    end else begin
      fb_req_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.q_start) begin
            width_q       <= bus.q_width;
            height_q      <= bus.q_height;
            channel_q     <= bus.q_channel;
            channel_out_q <= bus.q_channel_out;
            stride_q      <= bus.q_stride;
            state_q       <= bus.q_skip_pre ? ST_CSYNC : ST_PRE;
            fb_req_q      <= bus.q_skip_pre;
          end
        end
        ST_PRE: begin
          if (bus.pp_load_done) begin
            state_q  <= ST_CSYNC;
            fb_req_q <= 1'b1;
          end
        end
        ST_CSYNC: begin
          if (bus.bm_csync_done && bus.pe_csync_done) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (advance && frame_last) begin
            if (l_cho) begin
              state_q <= ST_POST;
            end else begin
              state_q  <= ST_CSYNC;
              fb_req_q <= 1'b1;
            end
          end
        end
        ST_POST: begin
          if (bus.pb_sync_done) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_fb_load_req      = fb_req_q;
  assign bus.o_layer_done       = done_q;
  assign bus.o_busy             = busy;
  assign bus.o_ctrl_csync_run   = (state_q == ST_CSYNC);
  assign bus.o_ctrl_psync_run   = (state_q == ST_PRE) || (state_q == ST_POST);
  assign bus.o_ctrl_psync_phase = (state_q == ST_POST) ? PH_POST : PH_PRE;
  assign bus.o_ctrl_data_run    = data_valid;
  assign bus.o_data_valid       = data_valid;

  // Position flags read as 0 while idle so the reset/idle output state is all zeros.
  assign bus.o_is_out_pos       = busy && out_pos;
  assign bus.o_is_first_row     = busy && f_row;
  assign bus.o_is_last_row      = busy && l_row;
  assign bus.o_is_first_col     = busy && f_col;
  assign bus.o_is_last_col      = busy && l_col;
  assign bus.o_is_first_chn     = busy && f_chn;
  assign bus.o_is_last_chn      = busy && l_chn;
  assign bus.o_is_first_chn_out = busy && f_cho;
  assign bus.o_is_last_chn_out  = busy && l_cho;
  assign bus.o_row              = row;
  assign bus.o_col              = col;
  assign bus.o_chn              = chn;
  assign bus.o_chn_out          = cho;

`ifdef CNN_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_data_q, perf_stall_q, perf_sync_q;

  // Saturating layer performance counters, cleared on each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_data_q  <= '0;
      perf_stall_q <= '0;
      perf_sync_q  <= '0;
    end else if (start_acc) begin
      perf_data_q  <= '0;
      perf_stall_q <= '0;
      perf_sync_q  <= '0;
    end else begin
      if (data_valid) perf_data_q <= sat_inc(perf_data_q);
      if (data_valid && !bus.i_data_ready) perf_stall_q <= sat_inc(perf_stall_q);
      if (state_q == ST_CSYNC || state_q == ST_PRE || state_q == ST_POST)
        perf_sync_q <= sat_inc(perf_sync_q);
    end
  end

  assign bus.o_perf_data_cyc  = perf_data_q;
  assign bus.o_perf_stall_cyc = perf_stall_q;
  assign bus.o_perf_sync_cyc  = perf_sync_q;
`endif

endmodule

// File: tb/tb_cnn_layer_seq.sv
// tb/tb_cnn_layer_seq.sv - randomized self-checking bench for cnn_layer_seq against a scan-list reference model
module tb_cnn_layer_seq;
  localparam int WS = 16;
  localparam int WC = 10;
  localparam int WT = 2;

  localparam int S_IDLE = 0, S_PRE = 1, S_CS = 2, S_DATA = 3, S_POST = 4;

  typedef struct {int row; int col; int chn; int co;} pos_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_layer_seq_if #(.W_SIZE(WS), .W_CHANNEL(WC), .W_STRIDE(WT)) bus ();

  cnn_layer_seq #(.W_SIZE(WS), .W_CHANNEL(WC), .W_STRIDE(WT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected scan list built from the layer parameters, plus the protocol state.
  pos_t mq[$];
  int   m_st = S_IDLE;
  bit   m_done = 0, m_fb = 0;
  int   mw = 1, mh = 1, mc = 1, mco = 1, ms = 1;
  int   n_fb = 0, n_done = 0, n_data = 0, n_acc = 0, n_outpos = 0, n_pre = 0;
  pos_t cur, hd;
  bit   act;

  always @(negedge clk) begin
    if (rst) begin
      m_st = S_IDLE; m_done = 0; m_fb = 0; mq.delete();
    end else begin
      act = (m_st != S_IDLE);
      cur = '{0, 0, 0, 0};
      if (act && mq.size() > 0) cur = mq[0];
      chk("busy",        bus.o_busy, act);
      chk("csync_run",   bus.o_ctrl_csync_run, m_st == S_CS);
      chk("psync_run",   bus.o_ctrl_psync_run, m_st == S_PRE || m_st == S_POST);
      chk("psync_phase", bus.o_ctrl_psync_phase, m_st == S_POST);
      chk("data_run",    bus.o_ctrl_data_run, m_st == S_DATA);
      chk("data_valid",  bus.o_data_valid, m_st == S_DATA);
      chk("fb_load_req", bus.o_fb_load_req, m_fb);
      chk("layer_done",  bus.o_layer_done, m_done);
      chk("row",     bus.o_row, cur.row);
      chk("col",     bus.o_col, cur.col);
      chk("chn",     bus.o_chn, cur.chn);
      chk("chn_out", bus.o_chn_out, cur.co);
      chk("first_row", bus.o_is_first_row, act && cur.row == 0);
      chk("last_row",  bus.o_is_last_row,  act && cur.row == mh - 1);
      chk("first_col", bus.o_is_first_col, act && cur.col == 0);
      chk("last_col",  bus.o_is_last_col,  act && cur.col == mw - 1);
      chk("first_chn", bus.o_is_first_chn, act && cur.chn == 0);
      chk("last_chn",  bus.o_is_last_chn,  act && cur.chn == mc - 1);
      chk("first_cho", bus.o_is_first_chn_out, act && cur.co == 0);
      chk("last_cho",  bus.o_is_last_chn_out,  act && cur.co == mco - 1);
      chk("out_pos",   bus.o_is_out_pos, act && (cur.row % ms == 0) && (cur.col % ms == 0));

      if (bus.o_fb_load_req) n_fb++;
      if (bus.o_layer_done) n_done++;
      if (bus.o_ctrl_data_run) n_data++;
      if (bus.o_ctrl_psync_run && !bus.o_ctrl_psync_phase) n_pre++;
      if (bus.o_data_valid && bus.i_data_ready) begin
        n_acc++;
        if (bus.o_is_out_pos) n_outpos++;
      end

      m_done = 0;
      m_fb   = 0;
      case (m_st)
        S_IDLE: if (bus.q_start) begin
          mw = int'(bus.q_width); mh = int'(bus.q_height); mc = int'(bus.q_channel);
          mco = int'(bus.q_channel_out); ms = (bus.q_stride == 0) ? 1 : int'(bus.q_stride);
          mq.delete();
          for (int o = 0; o < mco; o++)
            for (int r = 0; r < mh; r++)
              for (int ch = 0; ch < mc; ch++)
                for (int c = 0; c < mw; c++)
                  mq.push_back('{r, c, ch, o});
          m_st = bus.q_skip_pre ? S_CS : S_PRE;
          m_fb = bus.q_skip_pre;
        end
        S_PRE: if (bus.pp_load_done) begin m_st = S_CS; m_fb = 1; end
        S_CS:  if (bus.bm_csync_done && bus.pe_csync_done) m_st = S_DATA;
        S_DATA: begin
          chk("scan_list_nonempty", mq.size() > 0, 1);
          if (bus.i_data_ready && mq.size() > 0) begin
            hd = mq.pop_front();
            if (hd.row == mh - 1 && hd.col == mw - 1 && hd.chn == mc - 1) begin
              if (hd.co == mco - 1) m_st = S_POST;
              else begin m_st = S_CS; m_fb = 1; end
            end
          end
        end
        S_POST: if (bus.pb_sync_done) begin m_st = S_IDLE; m_done = 1; end
        default: m_st = S_IDLE;
      endcase
    end
  end

  // Environment: random sync handshakes and a ready pattern chosen per test.
  bit prev_dr = 0;
  task automatic drive_env(input int rmode);
    bus.bm_csync_done = 1'($urandom % 2);
    bus.pe_csync_done = 1'($urandom % 2);
    bus.pp_load_done  = 1'($urandom % 2);
    bus.pb_sync_done  = 1'($urandom % 2);
    case (rmode)
      0: bus.i_data_ready = 1'b1;
      1: bus.i_data_ready = (bus.o_ctrl_data_run && prev_dr) ? ~bus.i_data_ready : 1'b0;
      default: bus.i_data_ready = ($urandom_range(0, 3) != 0);
    endcase
    prev_dr = bus.o_ctrl_data_run;
  endtask

  task automatic set_layer(input int w, input int h, input int c, input int co, input int s, input bit skip);
    bus.q_width = WS'(w); bus.q_height = WS'(h); bus.q_channel = WC'(c);
    bus.q_channel_out = WC'(co); bus.q_stride = WT'(s); bus.q_skip_pre = skip;
  endtask

  task automatic run_layer(input int w, input int h, input int c, input int co, input int s,
                           input bit skip, input int rmode, input bit scramble);
    int d0;
    bit fin;
    set_layer(w, h, c, co, s, skip);
    bus.q_start = 1'b1;
    d0 = n_done;
    drive_env(rmode);
    @(posedge clk); #1;
    bus.q_start = 1'b0;
    fin = 0;
    for (int i = 0; i < 20000; i++) begin
      if (n_done != d0) begin fin = 1; break; end
      drive_env(rmode);
      if (scramble && bus.o_busy) begin
        bus.q_start = 1'($urandom % 2);
        set_layer($urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 4),
                  $urandom_range(1, 4), $urandom_range(0, 3), 1'($urandom % 2));
      end else begin
        bus.q_start = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.q_start = 1'b0;
    chk("layer_done_seen", fin, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_data_valid"}, bus.o_data_valid, 0);
    chk({tag, "_csync"}, bus.o_ctrl_csync_run, 0);
    chk({tag, "_psync"}, bus.o_ctrl_psync_run, 0);
    chk({tag, "_fb"}, bus.o_fb_load_req, 0);
    chk({tag, "_done"}, bus.o_layer_done, 0);
    chk({tag, "_pos"}, {bus.o_row, bus.o_col, bus.o_chn, bus.o_chn_out}, 0);
    chk({tag, "_flags"}, {bus.o_is_first_row, bus.o_is_first_col, bus.o_is_first_chn,
                          bus.o_is_first_chn_out, bus.o_is_out_pos}, 0);
  endtask

  int a0, f0, d0, dt0, o0, p0;
  bit reached;

  initial begin
    rst = 1'b1;
    bus.q_start = 1'b0;
    set_layer(1, 1, 1, 1, 1, 0);
    bus.bm_csync_done = 0; bus.pe_csync_done = 0; bus.pp_load_done = 0; bus.pb_sync_done = 0;
    bus.i_data_ready = 0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: 4x3x2, Cout 2, stride 1, ready high.
    a0 = n_acc; f0 = n_fb; d0 = n_done; dt0 = n_data;
    run_layer(4, 3, 2, 2, 1, 0, 0, 0);
    chk("t1_accepted", n_acc - a0, 48);
    chk("t1_fb_pulses", n_fb - f0, 2);
    chk("t1_done", n_done - d0, 1);
    chk("t1_data_cycles", n_data - dt0, 48);

    // 2: same layer, ready alternating 0,1 inside DATA.
    a0 = n_acc; dt0 = n_data;
    run_layer(4, 3, 2, 2, 1, 0, 1, 0);
    chk("t2_accepted", n_acc - a0, 48);
    chk("t2_data_cycles", n_data - dt0, 96);

    // 3: 4x4x1 stride 2.
    a0 = n_acc; o0 = n_outpos;
    run_layer(4, 4, 1, 1, 2, 0, 2, 0);
    chk("t3_accepted", n_acc - a0, 16);
    chk("t3_out_pos", n_outpos - o0, 4);

    // 4: skip pre-load.
    p0 = n_pre; f0 = n_fb;
    run_layer(3, 2, 1, 2, 3, 1, 2, 1);
    chk("t4_pre_cycles", n_pre - p0, 0);
    chk("t4_fb_pulses", n_fb - f0, 2);

    // 5: 1x1x1, Cout 1.
    dt0 = n_data; d0 = n_done;
    run_layer(1, 1, 1, 1, 0, 0, 0, 0);
    repeat (3) begin drive_env(0); @(posedge clk); #1; end
    chk("t5_data_cycles", n_data - dt0, 1);
    chk("t5_done_cycles", n_done - d0, 1);

    // 6: reset during DATA at row 1, busy starts dropped.
    set_layer(4, 3, 2, 2, 1, 0);
    bus.q_start = 1'b1;
    drive_env(0);
    @(posedge clk); #1;
    reached = 0;
    for (int i = 0; i < 500; i++) begin
      drive_env(0);
      bus.q_start = bus.o_busy;
      bus.q_width = WS'(7);
      @(posedge clk); #1;
      if (bus.o_ctrl_data_run && bus.o_row == 1) begin reached = 1; break; end
    end
    chk("t6_reached_row1", reached, 1);
    d0 = n_done;
    #2 rst = 1'b1;
    #1;
    check_all_zero("t6_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.q_start = 1'b0;
    repeat (4) begin drive_env(2); @(posedge clk); #1; end
    chk("t6_no_done_after_rst", n_done - d0, 0);
    a0 = n_acc;
    run_layer(4, 3, 2, 2, 1, 0, 2, 1);
    chk("t6_clean_scan", n_acc - a0, 48);

    // Randomized layers with random stalls, handshakes and busy-time register scrambling.
    for (int t = 0; t < 8; t++) begin
      run_layer($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(1, 3),
                $urandom_range(1, 3), $urandom_range(0, 3), 1'($urandom % 2), 2, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
